// File: rtl/alu_multicycle.sv
// 32-bit RV32I ALU: single-cycle arithmetic/logic, bit-serial shifts (one bit per cycle).
// Opcode encodings fall back to the standard RV32I values when arch_defines.v is not compiled in.
`ifndef RISCV_ALU_OP_REGS
`define RISCV_ALU_OP_REGS 7'b0110011
`endif
`ifndef RISCV_ALU_OP_IMM
`define RISCV_ALU_OP_IMM 7'b0010011
`endif
`ifndef RISCV_AUIPC
`define RISCV_AUIPC 7'b0010111
`endif

module alu_multicycle (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] alu_in1,
    input  logic [31:0] alu_in2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        shl_q, shl_d;
    logic        sra_q, sra_d;

    logic        is_alu_op;
    logic        shift_req;
    logic [4:0]  shamt;

    function automatic logic [31:0] shift_one(input logic [31:0] v, input logic left,
                                              input logic arith);
        if (left)
            return {v[30:0], 1'b0};
        else
            return {arith & v[31], v[31:1]};
    endfunction

    // Everything that completes in one cycle, including a zero-distance shift.
    function automatic logic [31:0] comb_result(input logic [6:0] op, input logic [2:0] f3,
                                                input logic f7, input logic [31:0] a,
                                                input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (op == `RISCV_AUIPC)
            return a + b;
        if (op != `RISCV_ALU_OP_REGS && op != `RISCV_ALU_OP_IMM)
            return 32'b0;
        case (f3)
            3'b000:  return (op == `RISCV_ALU_OP_REGS && f7) ? a - b : a + b;
            3'b010:  return (sa < sb) ? 32'd1 : 32'd0;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return a;
        endcase
    endfunction

    assign is_alu_op = (opcode == `RISCV_ALU_OP_REGS) || (opcode == `RISCV_ALU_OP_IMM);
    assign shift_req = is_alu_op && (funct3 == 3'b001 || funct3 == 3'b101);
    assign shamt     = alu_in2[4:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            work_q   <= 32'b0;
            result_q <= 32'b0;
            cnt_q    <= 5'd0;
            shl_q    <= 1'b0;
            sra_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            shl_q    <= shl_d;
            sra_q    <= sra_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        shl_d    = shl_q;
        sra_d    = sra_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (shift_req && shamt != 5'd0) begin
                        state_d = S_SHIFT;
                        work_d  = alu_in1;
                        cnt_d   = shamt;
                        shl_d   = (funct3 == 3'b001);
                        sra_d   = funct7_5;
                    end else begin
                        state_d  = S_DONE;
                        result_d = comb_result(opcode, funct3, funct7_5, alu_in1, alu_in2);
                    end
                end
            end
            S_SHIFT: begin
                work_d = shift_one(work_q, shl_q, sra_q);
                cnt_d  = cnt_q - 5'd1;
                // Last step: publish the final shifted value on the same edge.
                if (cnt_q == 5'd1) begin
                    state_d  = S_DONE;
                    result_d = shift_one(work_q, shl_q, sra_q);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        result = result_q;
    end

endmodule
